// File: rtl/conv2_pkg.sv
// Shared constants, FSM state encoding and bank indexing for the conv2 weight scheduler.
package conv2_pkg;
    localparam int WEIGHT_W    = 8;
    localparam int KERNEL_SIZE = 3;
    localparam int IN_CH       = 4;
    localparam int OUT_CH      = 16;
    localparam int DEPTH       = KERNEL_SIZE * IN_CH * OUT_CH;
    localparam int ADDR_W      = 8;
    localparam int BUS_W       = WEIGHT_W * OUT_CH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT_GO = 3'd2,
        ISSUE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Weight order in ROM and bank: output channel major, then input channel, then kernel row.
    function automatic logic [ADDR_W-1:0] idx(input int oc, input int ch, input logic [1:0] row);
        return ADDR_W'(oc * KERNEL_SIZE * IN_CH + ch * KERNEL_SIZE + int'(row));
    endfunction
endpackage

// File: rtl/conv2_weight_sched_wbank.sv
// Register-file bank holding one full conv2 weight set, with a single write port and
// a kernel-row read mux that fans out to all input-channel buses at once.
module conv2_wbank
    import conv2_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [WEIGHT_W-1:0]       wdata,
    input  logic [1:0]                row,
    output logic [IN_CH*BUS_W-1:0]    rdata
);
    logic [WEIGHT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Bus ch occupies rdata[ch*BUS_W +: BUS_W]; lane oc within it is oc*WEIGHT_W.
    for (genvar ch = 0; ch < IN_CH; ch++) begin : g_ch
        for (genvar oc = 0; oc < OUT_CH; oc++) begin : g_oc
            assign rdata[(ch*OUT_CH + oc)*WEIGHT_W +: WEIGHT_W] = mem[idx(oc, ch, row)];
        end
    end
endmodule

// File: rtl/conv2_weight_sched.sv
// Layer-2 weight sequencer: bursts the ROM into the bank, then issues kernel rows 0..2
// to the MAC array over valid/ready once layer 1 has finished; DONE allows a bank replay.
module conv2_weight_sched
    import conv2_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_start,
    input  logic                        conv1_end,
    input  logic                        restart,
    output logic                        rom_en,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [WEIGHT_W-1:0]         rom_dout,
    output logic                        w_valid,
    input  logic                        w_ready,
    output logic [1:0]                  w_row,
    output logic [WEIGHT_W*OUT_CH-1:0]  c2_w0,
    output logic [WEIGHT_W*OUT_CH-1:0]  c2_w1,
    output logic [WEIGHT_W*OUT_CH-1:0]  c2_w2,
    output logic [WEIGHT_W*OUT_CH-1:0]  c2_w3,
    output logic                        load_done,
    output logic                        sched_done,
    output logic                        busy
);
    // Handshake: a row transfers on any rising edge where w_valid && w_ready; while w_valid
    // is high, w_row and c2_w* do not change until that transfer happens.
    state_t                  state, state_nxt;
    logic [ADDR_W-1:0]       addr_cnt, rd_addr;
    logic                    rd_vld, go_seen, go, hs, enter_issue;
    logic [1:0]              rd_row;
    logic [IN_CH*BUS_W-1:0]  bank_row, w_bus;

    assign go          = go_seen | conv1_end;
    assign hs          = w_valid & w_ready;
    assign enter_issue = (state_nxt == ISSUE) && (state != ISSUE);
    assign rd_row      = enter_issue ? 2'd0 : ((w_row == 2'd2) ? 2'd2 : w_row + 2'd1);

    conv2_wbank u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rd_vld),
        .waddr (rd_addr),
        .wdata (rom_dout),
        .row   (rd_row),
        .rdata (bank_row)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_start) state_nxt = LOAD;
            LOAD:    if (rd_vld && rd_addr == ADDR_W'(DEPTH - 1)) state_nxt = WAIT_GO;
            WAIT_GO: if (go) state_nxt = ISSUE;
            ISSUE:   if (hs && w_row == 2'd2) state_nxt = DONE;
            DONE: begin
                if (load_start)   state_nxt = LOAD;
                else if (restart) state_nxt = ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rom_en     = (state == LOAD) && (addr_cnt < ADDR_W'(DEPTH));
        rom_addr   = addr_cnt;
        load_done  = (state == WAIT_GO) || (state == ISSUE) || (state == DONE);
        sched_done = (state == DONE);
        busy       = (state == LOAD) || (state == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_cnt <= '0;
            rd_vld   <= 1'b0;
            rd_addr  <= '0;
            go_seen  <= 1'b0;
            w_valid  <= 1'b0;
            w_row    <= 2'd0;
            w_bus    <= '0;
        end else begin
            rd_vld  <= rom_en;
            rd_addr <= rom_addr;
            // Held at zero outside LOAD so every burst starts at address 0.
            if (state != LOAD)  addr_cnt <= '0;
            else if (rom_en)    addr_cnt <= addr_cnt + ADDR_W'(1);

            if (enter_issue)    go_seen <= 1'b0;
            else if (conv1_end) go_seen <= 1'b1;

            if (enter_issue) begin
                w_valid <= 1'b1;
                w_row   <= 2'd0;
                w_bus   <= bank_row;
            end else if (state == ISSUE && hs) begin
                if (w_row == 2'd2) begin
                    w_valid <= 1'b0;
                end else begin
                    w_row <= w_row + 2'd1;
                    w_bus <= bank_row;
                end
            end
        end
    end

    assign c2_w0 = w_bus[0*BUS_W +: BUS_W];
    assign c2_w1 = w_bus[1*BUS_W +: BUS_W];
    assign c2_w2 = w_bus[2*BUS_W +: BUS_W];
    assign c2_w3 = w_bus[3*BUS_W +: BUS_W];
endmodule

// File: tb/tb_conv2_weight_sched.sv
// Directed bench for conv2_weight_sched: ROM model returns address+offset, a scoreboard
// queue holds expected rows and a negedge monitor checks every accepted row and ROM address.
module tb_conv2_weight_sched;
    import conv2_pkg::*;

    localparam int ROW_W = 2 + IN_CH * BUS_W;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       load_start = 1'b0;
    logic                       conv1_end = 1'b0;
    logic                       restart = 1'b0;
    logic                       w_ready = 1'b0;
    logic                       rom_en;
    logic [ADDR_W-1:0]          rom_addr;
    logic [WEIGHT_W-1:0]        rom_dout = '0;
    logic                       w_valid;
    logic [1:0]                 w_row;
    logic [BUS_W-1:0]           c2_w0, c2_w1, c2_w2, c2_w3;
    logic                       load_done, sched_done, busy;

    int                         checks = 0;
    int                         failures = 0;
    logic [ROW_W-1:0]           exp_q[$];
    logic [WEIGHT_W-1:0]        rom_off = '0;
    int                         rom_exp_addr = 0;
    int                         rom_en_cnt = 0;

    conv2_weight_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .conv1_end  (conv1_end),
        .restart    (restart),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_row      (w_row),
        .c2_w0      (c2_w0),
        .c2_w1      (c2_w1),
        .c2_w2      (c2_w2),
        .c2_w3      (c2_w3),
        .load_done  (load_done),
        .sched_done (sched_done),
        .busy       (busy)
    );

    // ---------------- clock / ROM model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom_en ? rom_addr + rom_off : 8'hEE;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] exp_row(input int r, input logic [7:0] off);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int ch = 0; ch < 4; ch++)
            for (int oc = 0; oc < 16; oc++)
                v[(ch*16 + oc)*8 +: 8] = off + 8'(oc*12 + ch*3 + r);
        v[ROW_W-1 -: 2] = 2'(r);
        return v;
    endfunction

    task automatic push_rows(input logic [7:0] off);
        for (int r = 0; r < 3; r++) exp_q.push_back(exp_row(r, off));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [ROW_W-1:0] act_r, exp_r;
        if (w_valid && w_ready) begin
            act_r = {w_row, c2_w3, c2_w2, c2_w1, c2_w0};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got row %0d accepted, expected no transfer", w_row);
            end else begin
                exp_r = exp_q.pop_front();
                if (act_r !== exp_r) begin
                    failures++;
                    $display("FAIL sb_row: got %h expected %h", act_r, exp_r);
                end
            end
        end
        if (rom_en) begin
            chk("rom_addr_seq", 64'(rom_addr), 64'(rom_exp_addr));
            rom_exp_addr++;
            rom_en_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle(input string tag);
        chk({tag, "_rom_en"},     64'(rom_en), 0);
        chk({tag, "_rom_addr"},   64'(rom_addr), 0);
        chk({tag, "_w_valid"},    64'(w_valid), 0);
        chk({tag, "_w_row"},      64'(w_row), 0);
        chk({tag, "_c2_w_zero"},  64'(|{c2_w3, c2_w2, c2_w1, c2_w0}), 0);
        chk({tag, "_load_done"},  64'(load_done), 0);
        chk({tag, "_sched_done"}, 64'(sched_done), 0);
        chk({tag, "_busy"},       64'(busy), 0);
        chk({tag, "_state"},      64'(dut.state), 64'(IDLE));
    endtask

    // Call just after the edge that entered LOAD; returns cycles until load_done is seen.
    task automatic wait_load_done(output int cnt);
        cnt = 0;
        while (cnt < 400) begin
            @(negedge clk);
            if (load_done) break;
            @(posedge clk);
            cnt++;
        end
    endtask

    task automatic wait_sched_done(input string tag);
        int n;
        n = 0;
        while (!sched_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_sched_done"}, 64'(sched_done), 1);
    endtask

    task automatic pulse_load();
        @(posedge clk); #1 load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        int stray;
        int ld_drop;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Full load with conv1_end during LOAD, then three zero-bubble rows.
        w_ready = 1'b1;
        rom_exp_addr = 0;
        rom_en_cnt = 0;
        push_rows(8'h00);
        load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
        fork
            begin
                repeat (50) @(posedge clk);
                #1 conv1_end = 1'b1;
                @(posedge clk); #1 conv1_end = 1'b0;
            end
            wait_load_done(cnt);
        join
        chk("load_done_latency", 64'(cnt), 193);
        chk("rom_en_cycles", 64'(rom_en_cnt), 192);
        chk("wait_go_valid", 64'(w_valid), 0);
        chk("wait_go_state", 64'(dut.state), 64'(WAIT_GO));
        @(negedge clk);
        chk("issue_state", 64'(dut.state), 64'(ISSUE));
        chk("issue_busy", 64'(busy), 1);
        chk("row0_valid", 64'(w_valid), 1);
        chk("row0_w0_lane0", 64'(c2_w0[7:0]), 8'h00);
        chk("row0_w0_lane1", 64'(c2_w0[15:8]), 8'h0C);
        chk("row0_w0_lane15", 64'(c2_w0[127:120]), 8'hB4);
        @(negedge clk);
        chk("row1_index", 64'(w_row), 1);
        @(negedge clk);
        chk("row2_index", 64'(w_row), 2);
        chk("row2_w3_lane15", 64'(c2_w3[127:120]), 8'hBF);
        @(negedge clk);
        chk("a_sched_done", 64'(sched_done), 1);
        chk("a_valid_drop", 64'(w_valid), 0);
        chk("a_busy_drop", 64'(busy), 0);
        chk("a_sb_drain", 64'(exp_q.size()), 0);

        // Reload from DONE, late conv1_end, backpressure on row 1.
        rom_exp_addr = 0;
        rom_en_cnt = 0;
        push_rows(8'h00);
        pulse_load();
        wait_load_done(cnt);
        chk("b_load_done_latency", 64'(cnt), 193);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (w_valid) stray++;
        end
        chk("b_no_valid_waiting", 64'(stray), 0);
        @(posedge clk); #1 conv1_end = 1'b1;
        @(negedge clk);
        chk("b_valid_before_go", 64'(w_valid), 0);
        @(posedge clk); #1 conv1_end = 1'b0;
        @(negedge clk);
        chk("b_row0_valid", 64'(w_valid), 1);
        chk("b_row0_index", 64'(w_row), 0);
        @(posedge clk); #1 w_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(w_valid), 1);
            chk("bp_row", 64'(w_row), 1);
            chk("bp_w1_lane0", 64'(c2_w1[7:0]), 8'h04);
        end
        @(posedge clk); #1 w_ready = 1'b1;
        @(negedge clk);
        chk("bp_first_ready_row", 64'(w_row), 1);
        @(negedge clk);
        chk("bp_accepted_row", 64'(w_row), 2);
        wait_sched_done("b");
        chk("b_sb_drain", 64'(exp_q.size()), 0);

        // Restart from DONE replays the bank without touching the ROM.
        rom_en_cnt = 0;
        push_rows(8'h00);
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        @(negedge clk);
        chk("c_valid", 64'(w_valid), 1);
        chk("c_row", 64'(w_row), 0);
        chk("c_sched_clear", 64'(sched_done), 0);
        ld_drop = 0;
        cnt = 0;
        while (!sched_done && cnt < 50) begin
            if (!load_done) ld_drop++;
            @(negedge clk);
            cnt++;
        end
        chk("c_sched_done", 64'(sched_done), 1);
        chk("c_load_done_held", 64'(ld_drop), 0);
        chk("c_rom_idle", 64'(rom_en_cnt), 0);
        chk("c_sb_drain", 64'(exp_q.size()), 0);

        // restart and load_start together: load wins.
        rom_exp_addr = 0;
        rom_en_cnt = 0;
        @(posedge clk); #1 restart = 1'b1; load_start = 1'b1;
        @(posedge clk); #1 restart = 1'b0; load_start = 1'b0;
        @(negedge clk);
        chk("d_state", 64'(dut.state), 64'(LOAD));
        chk("d_sched_done", 64'(sched_done), 0);
        chk("d_load_done", 64'(load_done), 0);
        chk("d_valid", 64'(w_valid), 0);
        chk("d_busy", 64'(busy), 1);
        chk("d_rom_en", 64'(rom_en), 1);

        // Reset in the middle of the burst.
        cnt = 0;
        while (rom_addr != 8'd100 && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("e_at_addr100", 64'(rom_addr), 100);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("e_rst");

        // Fresh load after reset with different ROM contents.
        rom_off = 8'h5A;
        rom_exp_addr = 0;
        rom_en_cnt = 0;
        push_rows(8'h5A);
        @(posedge clk); #1 load_start = 1'b1; conv1_end = 1'b1;
        @(posedge clk); #1 load_start = 1'b0; conv1_end = 1'b0;
        wait_load_done(cnt);
        chk("f_load_done_latency", 64'(cnt), 193);
        chk("f_rom_en_cycles", 64'(rom_en_cnt), 192);
        wait_sched_done("f");
        chk("f_sb_drain", 64'(exp_q.size()), 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv2_weight_sched.md
Name: conv2_weight_sched

Overview:
Controller that sequences the layer-2 weight path. On request it bursts all conv2 weights from the single-port weight ROM (1-cycle read latency) into an internal bank. After layer 1 finishes, it issues the weights to the conv2 MAC array one kernel row at a time over a valid/ready handshake, four input-channel buses of 16 output-channel lanes each. It supports re-issuing the held weights (restart) without a ROM reload.

Parameters:
WEIGHT_W, 8, weight bit width
KERNEL_SIZE, 3, kernel rows (and columns per row group)
IN_CH, 4, input channels; fixed to 4 buses
OUT_CH, 16, output channels = lanes per bus
DEPTH, KERNEL_SIZE*IN_CH*OUT_CH (192), weights in ROM
ADDR_W, 8, ROM address width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
load_start  in  1  pulse; begin ROM fetch (honoured in IDLE/DONE only)
conv1_end  in  1  layer-1 finished (pulse or level)
restart  in  1  pulse; re-issue rows 0..2 from bank (DONE only)
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM address
rom_dout  in  WEIGHT_W  ROM data, valid 1 cycle after rom_en
w_valid  out  1  weight row presented
w_ready  in  1  MAC array accepts row
w_row  out  2  kernel row index of presented data (0..2)
c2_w0..c2_w3  out  WEIGHT_W*OUT_CH each  per-input-channel weight bus; lane oc = bits [oc*8+:8]
load_done  out  1  bank holds a full weight set
sched_done  out  1  all 3 rows accepted
busy  out  1  state is LOAD or ISSUE

Behaviour:
- All state updates on posedge clk. rst_n=0 at any edge (including mid-LOAD/ISSUE) -> IDLE. Counters, bank, conv1_end latch, w_valid, w_row, c2_w*, load_done, sched_done = 0. rom_en=0, rom_addr=0.
- Bank layout: address a = oc*12 + ch*3 + row. Bus c2_w{ch} lane oc for row r = bank[oc*12 + ch*3 + r].
- FSM states: IDLE, LOAD, WAIT_GO, ISSUE, DONE.
- IDLE: load_start -> LOAD with addr_cnt=0. load_done=0.
- LOAD: rom_en = (addr_cnt < DEPTH), rom_addr = addr_cnt, addr_cnt++ each cycle up to DEPTH. Registered rd_vld<=rom_en, rd_addr<=rom_addr. When rd_vld is set: bank[rd_addr] <= rom_dout. When rd_vld && rd_addr==DEPTH-1 -> WAIT_GO. LOAD lasts DEPTH+1 = 193 cycles. load_done=1 from the first WAIT_GO cycle.
- conv1_end latch: sticky set on any cycle conv1_end=1 (in any state incl. LOAD). Cleared on transition into ISSUE.
- WAIT_GO: latch set (or conv1_end this cycle) -> ISSUE. The same edge loads the c2_w* regs with row 0, sets w_row=0 and w_valid=1.
- ISSUE: w_valid stays 1. Data and w_row are held stable until handshake.
  - On w_valid&&w_ready with w_row<2: w_row++ and c2_w* load the next row at that edge. Zero-bubble: a row can be accepted every cycle.
  - On handshake with w_row==2: w_valid<=0 -> DONE, sched_done<=1.
  - c2_w* hold their last value after w_valid drops.
- DONE: sched_done=1, load_done=1.
  - load_start -> LOAD; load_done and sched_done clear.
  - restart -> ISSUE row 0 (same as the WAIT_GO entry); sched_done clears.
  - load_start and restart in the same cycle: load_start wins.
- load_start in LOAD/WAIT_GO/ISSUE and restart outside DONE: ignored.
- w_ready while w_valid=0: ignored.
- rom_dout is used only when rd_vld is set. No arithmetic on the data; widths pass through unchanged.

Decomposition:
- Shared package conv2_pkg: WEIGHT_W, KERNEL_SIZE, IN_CH, OUT_CH, DEPTH, state enum localparams (IDLE=0..DONE=4), bank index function idx(oc,ch,row).
- One natural sub-module: conv2_wbank. It holds the DEPTH x WEIGHT_W register file with a write port (addr, data, we) and a row-read mux port (row -> 4 x 128-bit buses). The FSM stays in conv2_weight_sched.

Test Plan:
- ROM model bank[a]=a. Pulse load_start, w_ready=1, conv1_end at cycle 50 (during LOAD):
  - rom_en high exactly 192 cycles, addr 0..191.
  - load_done rises 193 cycles after LOAD entry; ISSUE follows the next cycle.
  - Row0: c2_w0 lane0=0x00, lane1=0x0C, lane15=0xB4.
  - Row2: c2_w3 lane15=0xBF.
  - Three back-to-back handshakes, then sched_done=1.
- Backpressure: w_ready=0 for 5 cycles on row1 -> w_valid=1, w_row=1, c2_w1 lane0=0x04 held stable; accepted on the first ready cycle.
- conv1_end arrives 20 cycles after load_done -> w_valid stays 0 until the cycle after conv1_end, then row0 issues.
- In DONE, pulse restart -> rows 0..2 re-issued with identical data, rom_en stays 0, load_done stays 1.
- In DONE, restart+load_start same cycle -> LOAD entered, sched_done=0, load_done=0, no w_valid.
- rst_n=0 for 1 cycle at LOAD address 100 -> next cycle all outputs 0, state IDLE. A new load_start reloads from address 0.
